pll_init_seq: RTL



---
 rtl/pll_init_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pll_init_seq
//  Brief    : Reset / loop-filter / lock-qualification / relock sequencer for
//             NUM_PLL PLLs sharing one programming word. Optional status
//             outputs (state_o, retry_o, loss_cnt) under PLL_INIT_STATUS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_init_seq #(
    parameter int NUM_PLL          = 1,
    parameter int CLK_PERIOD       = 20,
    parameter int MULTI_FAC        = 16,
    parameter int RST_HOLD_NS      = 1000,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRY        = 3,
    parameter int ICP_STEP         = 4
) (
    input  logic               init_clk,
    input  logic               reset,
    input  logic [NUM_PLL-1:0] pll_lock,
    output logic [NUM_PLL-1:0] pll_rst,
    output logic [5:0]         icpsel,
    output logic [2:0]         lpfres,
    output logic               lock,
    output logic               fail
`ifdef PLL_INIT_STATUS_EN
    ,
    output logic [2:0]         state_o,
    output logic [3:0]         retry_o,
    output logic [7:0]         loss_cnt
`endif
);

    localparam int c_RST_CYC_RAW = (RST_HOLD_NS + CLK_PERIOD - 1) / CLK_PERIOD;
    localparam int c_RST_CYC     = (c_RST_CYC_RAW < 1) ? 1 : c_RST_CYC_RAW;

    // One shared counter serves every timed state, so size it for the longest.
    localparam int c_CNT_MAX_A = (c_RST_CYC > STABLE_CYC) ? c_RST_CYC : STABLE_CYC;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > LOCK_TIMEOUT_CYC) ? c_CNT_MAX_A : LOCK_TIMEOUT_CYC;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(c_RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(STABLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [5:0] c_ICP_BASE = (MULTI_FAC <= 8)  ? 6'd8  :
                                        (MULTI_FAC <= 16) ? 6'd16 : 6'd32;
    localparam logic [2:0] c_LPF_BASE = (MULTI_FAC <= 8)  ? 3'd2  :
                                        (MULTI_FAC <= 16) ? 3'd3  : 3'd4;
    localparam logic [6:0] c_ICP_STEP = 7'(ICP_STEP);
    localparam logic [3:0] c_MAX_RTY  = 4'(MAX_RETRY);

    localparam logic [NUM_PLL-1:0] c_ALL_ONES = {NUM_PLL{1'b1}};

    localparam logic [2:0] c_ST_RST_HOLD  = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_QUALIFY   = 3'd2;
    localparam logic [2:0] c_ST_LOCKED    = 3'd3;
    localparam logic [2:0] c_ST_RETRY     = 3'd4;
    localparam logic [2:0] c_ST_FAIL      = 3'd5;

    logic [NUM_PLL-1:0] r_sync1;
    logic [NUM_PLL-1:0] r_sync2;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_retry;
    logic [NUM_PLL-1:0] r_pll_rst;
    logic [5:0]         r_icpsel;
    logic [2:0]         r_lpfres;
    logic               r_lock;
    logic               r_fail;
`ifdef PLL_INIT_STATUS_EN
    logic [7:0]         r_loss;
`endif

    logic               w_all_lk;
    logic [3:0]         w_retry_nxt;
    logic [6:0]         w_icp_sum;
    logic [5:0]         w_icp_nxt;

    assign w_all_lk    = &r_sync2;
    assign w_retry_nxt = r_retry + 4'd1;
    assign w_icp_sum   = {1'b0, r_icpsel} + c_ICP_STEP;
    assign w_icp_nxt   = (w_icp_sum > 7'd63) ? 6'd63 : w_icp_sum[5:0];

    // Raw lock flags come from other clock domains.
    always_ff @(posedge init_clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge init_clk) begin
        if (reset) begin
            r_state   <= c_ST_RST_HOLD;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= c_ALL_ONES;
            r_icpsel  <= c_ICP_BASE;
            r_lpfres  <= c_LPF_BASE;
            r_lock    <= 1'b0;
            r_fail    <= 1'b0;
`ifdef PLL_INIT_STATUS_EN
            r_loss    <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_RST_HOLD: begin
                    r_pll_rst <= c_ALL_ONES;
                    r_lock    <= 1'b0;
                    if (r_cnt == c_RST_LAST) begin
                        r_pll_rst <= '0;
                        r_cnt     <= '0;
                        r_state   <= c_ST_WAIT_LOCK;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_WAIT_LOCK: begin
                    if (w_all_lk) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_QUALIFY;
                    end else if (r_cnt == c_TO_LAST) begin
                        // PLLs go back into reset before icpsel is touched.
                        r_pll_rst <= c_ALL_ONES;
                        r_cnt     <= '0;
                        r_state   <= c_ST_RETRY;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_QUALIFY: begin
                    if (!w_all_lk) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_WAIT_LOCK;
                    end else if (r_cnt == c_STB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_LOCKED;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_ST_LOCKED: begin
                    if (w_all_lk) begin
                        r_lock <= 1'b1;
                    end else begin
                        // Relock keeps the tuned icpsel but grants a fresh retry budget.
                        r_lock    <= 1'b0;
                        r_pll_rst <= c_ALL_ONES;
                        r_cnt     <= '0;
                        r_retry   <= '0;
                        r_state   <= c_ST_RST_HOLD;
`ifdef PLL_INIT_STATUS_EN
                        if (r_loss != 8'hFF) begin
                            r_loss <= r_loss + 8'd1;
                        end
`endif
                    end
                end

                c_ST_RETRY: begin
                    r_retry   <= w_retry_nxt;
                    r_pll_rst <= c_ALL_ONES;
                    r_cnt     <= '0;
                    if (w_retry_nxt == c_MAX_RTY) begin
                        r_fail  <= 1'b1;
                        r_state <= c_ST_FAIL;
                    end else begin
                        r_icpsel <= w_icp_nxt;
                        r_state  <= c_ST_RST_HOLD;
                    end
                end

                c_ST_FAIL: begin
                    r_pll_rst <= c_ALL_ONES;
                    r_lock    <= 1'b0;
                    r_fail    <= 1'b1;
                end

                default: begin
                    r_pll_rst <= c_ALL_ONES;
                    r_lock    <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= c_ST_RST_HOLD;
                end
            endcase
        end
    end

    assign pll_rst = r_pll_rst;
    assign icpsel  = r_icpsel;
    assign lpfres  = r_lpfres;
    assign lock    = r_lock;
    assign fail    = r_fail;

`ifdef PLL_INIT_STATUS_EN
    assign state_o  = r_state;
    assign retry_o  = r_retry;
    assign loss_cnt = r_loss;
`endif

endmodule
`default_nettype wire
